arm_mem_bridge: RTL and testbench

Serialises the ARM multicycle core's instruction-fetch and data-access requests onto one single-ported, variable-latency memory bus with a req/ready handshake. Sits directly downstream of the `arm` core: consumes its `PC`, `ALUResult`, `WriteData`, `byteEnable` and `MemWrite`, and returns `Instr` and `ReadData`. Asserts `stall` while a transaction is in flight so the core's controller can hold its state.

---
 rtl/arm_mem_bridge_if.sv | 21 ++
 rtl/arm_mem_bridge.sv | 249 ++++++++++++++++++++++++
 tb/tb_arm_mem_bridge.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arm_mem_bridge_if.sv
// Single-ported memory bus between arm_mem_bridge (master) and the memory (slave).
// Request is held with stable attributes until the slave raises mem_ready.
interface arm_mem_bridge_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/arm_mem_bridge.sv
// Serialises ARM core fetch and data requests onto one variable-latency memory bus.
// Optional one-entry instruction buffer: define ARM_MEM_BRIDGE_FETCH_BUF_EN.
//
// state  | meaning
// IDLE   | no transaction; sample data_req (priority) and fetch_req
// BUS    | mem_req high, waiting for mem_ready or the wait-cycle limit
// DONE   | one-cycle valid pulse; continue with a pending fetch if one is held
module arm_mem_bridge #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] PC,
    input  logic        data_req,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    input  logic [3:0]  byteEnable,
    output logic [31:0] Instr,
    output logic        instr_valid,
    output logic [31:0] ReadData,
    output logic        data_valid,
    output logic        stall,
    output logic        bus_err,
    arm_mem_bridge_if.master mem
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Wait budget is a down-counter: loaded on BUS entry, abort when it hits zero.
    localparam logic [7:0] WAIT_LOAD = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        instr_valid_q, instr_valid_d;
    logic        data_valid_q, data_valid_d;
    logic        bus_err_q, bus_err_d;
    logic        is_fetch_q, is_fetch_d;
    logic        pend_vld_q, pend_vld_d;
    logic [29:0] pend_pc_q, pend_pc_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
`ifdef ARM_MEM_BRIDGE_FETCH_BUF_EN
    logic        buf_vld_q, buf_vld_d;
    logic [29:0] buf_tag_q, buf_tag_d;
    logic [31:0] buf_data_q, buf_data_d;
`endif

    logic        start_fetch;
    logic [29:0] fetch_word;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^{PC[1:0], ALUResult[1:0]};

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        rdata_d       = rdata_q;
        instr_valid_d = 1'b0;
        data_valid_d  = 1'b0;
        bus_err_d     = bus_err_q;
        is_fetch_d    = is_fetch_q;
        pend_vld_d    = pend_vld_q;
        pend_pc_d     = pend_pc_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_be_d      = mem_be_q;
        wait_cnt_d    = wait_cnt_q;
        start_fetch   = 1'b0;
        fetch_word    = pend_pc_q;
`ifdef ARM_MEM_BRIDGE_FETCH_BUF_EN
        buf_vld_d     = buf_vld_q;
        buf_tag_d     = buf_tag_q;
        buf_data_d    = buf_data_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (data_req) begin
                    state_d    = S_BUS;
                    is_fetch_d = 1'b0;
                    mem_we_d   = MemWrite;
                    mem_addr_d = {ALUResult[31:2], 2'b00};
                    wait_cnt_d = WAIT_LOAD;
                    if (MemWrite) begin
                        mem_wdata_d = WriteData;
                        mem_be_d    = byteEnable;
                    end else begin
                        mem_be_d    = 4'hF;
                    end
                    // The younger instruction's fetch waits behind the data access.
                    if (fetch_req) begin
                        pend_vld_d = 1'b1;
                        pend_pc_d  = PC[31:2];
                    end
`ifdef ARM_MEM_BRIDGE_FETCH_BUF_EN
                    if (MemWrite && buf_vld_q && (ALUResult[31:2] == buf_tag_q)) begin
                        buf_vld_d = 1'b0;
                    end
`endif
                end else if (fetch_req) begin
`ifdef ARM_MEM_BRIDGE_FETCH_BUF_EN
                    if (buf_vld_q && (PC[31:2] == buf_tag_q)) begin
                        state_d       = S_DONE;
                        instr_d       = buf_data_q;
                        instr_valid_d = 1'b1;
                    end else begin
                        start_fetch = 1'b1;
                        fetch_word  = PC[31:2];
                    end
`else
                    start_fetch = 1'b1;
                    fetch_word  = PC[31:2];
`endif
                end
            end

            S_BUS: begin
                if (fetch_req && !pend_vld_q) begin
                    pend_vld_d = 1'b1;
                    pend_pc_d  = PC[31:2];
                end
                if (mem.mem_ready) begin
                    state_d = S_DONE;
                    if (is_fetch_q) begin
                        instr_d       = mem.mem_rdata;
                        instr_valid_d = 1'b1;
`ifdef ARM_MEM_BRIDGE_FETCH_BUF_EN
                        buf_vld_d  = 1'b1;
                        buf_tag_d  = mem_addr_q[31:2];
                        buf_data_d = mem.mem_rdata;
`endif
                    end else begin
                        if (!mem_we_q) begin
                            rdata_d = mem.mem_rdata;
                        end
                        data_valid_d = 1'b1;
                    end
                end else if (wait_cnt_q == 8'd0) begin
                    // Abort: deliver zero so the core still sees a completion.
                    state_d   = S_DONE;
                    bus_err_d = 1'b1;
`ifdef ARM_MEM_BRIDGE_FETCH_BUF_EN
                    buf_vld_d = 1'b0;
`endif
                    if (is_fetch_q) begin
                        instr_d       = 32'h0;
                        instr_valid_d = 1'b1;
                    end else begin
                        if (!mem_we_q) begin
                            rdata_d = 32'h0;
                        end
                        data_valid_d = 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - 8'd1;
                end
            end

            S_DONE: begin
                if (pend_vld_q) begin
                    pend_vld_d  = 1'b0;
                    start_fetch = 1'b1;
                    fetch_word  = pend_pc_q;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (start_fetch) begin
            state_d    = S_BUS;
            is_fetch_d = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = {fetch_word, 2'b00};
            mem_be_d   = 4'hF;
            wait_cnt_d = WAIT_LOAD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            instr_q       <= 32'h0;
            rdata_q       <= 32'h0;
            instr_valid_q <= 1'b0;
            data_valid_q  <= 1'b0;
            bus_err_q     <= 1'b0;
            is_fetch_q    <= 1'b0;
            pend_vld_q    <= 1'b0;
            pend_pc_q     <= 30'h0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 32'h0;
            mem_wdata_q   <= 32'h0;
            mem_be_q      <= 4'h0;
            wait_cnt_q    <= 8'h0;
`ifdef ARM_MEM_BRIDGE_FETCH_BUF_EN
            buf_vld_q     <= 1'b0;
            buf_tag_q     <= 30'h0;
            buf_data_q    <= 32'h0;
`endif
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            rdata_q       <= rdata_d;
            instr_valid_q <= instr_valid_d;
            data_valid_q  <= data_valid_d;
            bus_err_q     <= bus_err_d;
            is_fetch_q    <= is_fetch_d;
            pend_vld_q    <= pend_vld_d;
            pend_pc_q     <= pend_pc_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_be_q      <= mem_be_d;
            wait_cnt_q    <= wait_cnt_d;
`ifdef ARM_MEM_BRIDGE_FETCH_BUF_EN
            buf_vld_q     <= buf_vld_d;
            buf_tag_q     <= buf_tag_d;
            buf_data_q    <= buf_data_d;
`endif
        end
    end

    assign Instr         = instr_q;
    assign instr_valid   = instr_valid_q;
    assign ReadData      = rdata_q;
    assign data_valid    = data_valid_q;
    assign stall         = (state_q != S_IDLE);
    assign bus_err       = bus_err_q;
    assign mem.mem_req   = (state_q == S_BUS);
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_be    = mem_be_q;

endmodule

// File: tb/tb_arm_mem_bridge.sv
// Self-checking bench for arm_mem_bridge: vector table plus hand-written corner sequences,
// with a bus responder and a valid-pulse scoreboard.
module tb_arm_mem_bridge;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        fetch_req;
    logic [31:0] PC;
    logic        data_req;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [3:0]  byteEnable;
    logic [31:0] Instr;
    logic        instr_valid;
    logic [31:0] ReadData;
    logic        data_valid;
    logic        stall;
    logic        bus_err;

    arm_mem_bridge_if mif ();

    arm_mem_bridge #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .PC         (PC),
        .data_req   (data_req),
        .MemWrite   (MemWrite),
        .ALUResult  (ALUResult),
        .WriteData  (WriteData),
        .byteEnable (byteEnable),
        .Instr      (Instr),
        .instr_valid(instr_valid),
        .ReadData   (ReadData),
        .data_valid (data_valid),
        .stall      (stall),
        .bus_err    (bus_err),
        .mem        (mif)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          waits;
        logic [31:0] rdata;
    } bus_t;

    typedef struct {
        logic        is_fetch;
        logic [31:0] val;
        int          at_cyc;
    } exp_t;

    typedef struct {
        logic        is_data;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          waits;
        logic [31:0] rdata;
        logic [31:0] exp_val;
    } vec_t;

    bus_t        bq[$];
    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] last_wdata = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bus responder: pops one expected transaction per request, checks attributes, inserts waits.
    bus_t cur;
    logic active = 1'b0;
    int   wcnt   = 0;
    initial begin
        mif.mem_ready = 1'b0;
        mif.mem_rdata = 32'h0;
    end
    always @(negedge clk) begin
        if (!reset) begin
            mif.mem_ready = 1'b0;
            active = 1'b0;
        end else if (mif.mem_req) begin
            if (!active) begin
                if (bq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_mem_req: got addr %h expected no request", mif.mem_addr);
                    cur = '{1'b0, 32'h0, 32'h0, 4'h0, 255, 32'h0};
                end else begin
                    cur = bq.pop_front();
                end
                active = 1'b1;
                wcnt = 0;
            end
            check("mem_we",    {31'b0, mif.mem_we}, {31'b0, cur.we});
            check("mem_addr",  mif.mem_addr,  cur.addr);
            check("mem_be",    {28'b0, mif.mem_be}, {28'b0, cur.be});
            check("mem_wdata", mif.mem_wdata, cur.wdata);
            if (wcnt < cur.waits) begin
                mif.mem_ready = 1'b0;
                mif.mem_rdata = 32'hDEADBEEF;
                wcnt++;
            end else begin
                mif.mem_ready = 1'b1;
                mif.mem_rdata = cur.rdata;
            end
        end else begin
            active = 1'b0;
            mif.mem_ready = 1'b0;
        end
    end

    // Scoreboard: every valid pulse must match the oldest expectation in kind, cycle and data.
    exp_t e;
    always @(negedge clk) begin
        if (reset && (instr_valid || data_valid)) begin
            if (instr_valid && data_valid) begin
                check("both_valid", 32'h1, 32'h0);
            end
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got instr_valid=%b data_valid=%b expected none", instr_valid, data_valid);
            end else begin
                e = exp_q.pop_front();
                check("valid_kind",  {31'b0, instr_valid}, {31'b0, e.is_fetch});
                check("valid_cycle", 32'(cyc), 32'(e.at_cyc));
                check("valid_data",  e.is_fetch ? Instr : ReadData, e.val);
            end
        end
    end

    task automatic push_bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input int waits, input logic [31:0] rdata);
        bus_t b;
        b.we    = we;
        b.addr  = addr & 32'hFFFF_FFFC;
        b.waits = waits;
        b.rdata = rdata;
        if (we) begin
            b.wdata    = wdata;
            b.be       = be;
            last_wdata = wdata;
        end else begin
            b.wdata = last_wdata;
            b.be    = 4'hF;
        end
        bq.push_back(b);
    endtask

    task automatic push_exp(input logic is_fetch, input logic [31:0] val, input int at_cyc);
        exp_t x;
        x.is_fetch = is_fetch;
        x.val      = val;
        x.at_cyc   = at_cyc;
        exp_q.push_back(x);
    endtask

    task automatic issue(input logic dreq, input logic dwe, input logic [31:0] daddr,
                         input logic [31:0] dwdata, input logic [3:0] dbe,
                         input logic freq, input logic [31:0] pc);
        data_req   = dreq;
        MemWrite   = dwe;
        ALUResult  = daddr;
        WriteData  = dwdata;
        byteEnable = dbe;
        fetch_req  = freq;
        PC         = pc;
        step();
        data_req  = 1'b0;
        fetch_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (stall && n < budget) begin
            step();
            n++;
        end
        check("idle_reached", {31'b0, stall}, 32'h0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_Instr"},       Instr, 32'h0);
        check({tag, "_ReadData"},    ReadData, 32'h0);
        check({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'h0);
        check({tag, "_data_valid"},  {31'b0, data_valid}, 32'h0);
        check({tag, "_stall"},       {31'b0, stall}, 32'h0);
        check({tag, "_bus_err"},     {31'b0, bus_err}, 32'h0);
        check({tag, "_mem_req"},     {31'b0, mif.mem_req}, 32'h0);
        check({tag, "_mem_we"},      {31'b0, mif.mem_we}, 32'h0);
        check({tag, "_mem_addr"},    mif.mem_addr, 32'h0);
        check({tag, "_mem_wdata"},   mif.mem_wdata, 32'h0);
        check({tag, "_mem_be"},      {28'b0, mif.mem_be}, 32'h0);
    endtask

    vec_t vecs[6];

    initial begin
        int c;
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 0, 32'hE281_1001, 32'hE281_1001};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 3, 32'h1234_5678, 32'h1234_5678};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0043, 32'hAABB_CCDD, 4'h3, 0, 32'h0, 32'h1234_5678};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 1, 32'hE3A0_0005, 32'hE3A0_0005};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0007, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0100, 32'h1122_3344, 4'hF, 2, 32'h0, 32'hCAFE_F00D};

        reset = 1'b0; fetch_req = 1'b0; PC = 32'h0; data_req = 1'b0; MemWrite = 1'b0;
        ALUResult = 32'h0; WriteData = 32'h0; byteEnable = 4'h0;
        step();
        step();
        check_all_zero("rst");
        reset = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            c = cyc;
            push_bus(vecs[i].is_data ? vecs[i].we : 1'b0, vecs[i].addr, vecs[i].wdata,
                     vecs[i].be, vecs[i].waits, vecs[i].rdata);
            push_exp(!vecs[i].is_data, vecs[i].exp_val, c + 2 + vecs[i].waits);
            if (vecs[i].is_data)
                issue(1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, 1'b0, 32'h0);
            else
                issue(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, vecs[i].addr);
            wait_idle(300);
        end

        // Simultaneous data + fetch: data first, pending fetch right after DONE.
        c = cyc;
        push_bus(1'b0, 32'h30, 32'h0, 4'h0, 0, 32'h0BAD_C0DE);
        push_bus(1'b0, 32'h108, 32'h0, 4'h0, 0, 32'hE080_0001);
        push_exp(1'b0, 32'h0BAD_C0DE, c + 2);
        push_exp(1'b1, 32'hE080_0001, c + 4);
        issue(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 1'b1, 32'h108);
        check("pair_req_n1",   {31'b0, mif.mem_req}, 32'h1);
        check("pair_stall_n1", {31'b0, stall}, 32'h1);
        step();
        check("pair_req_n2",   {31'b0, mif.mem_req}, 32'h0);
        check("pair_stall_n2", {31'b0, stall}, 32'h1);
        step();
        check("pair_req_n3",   {31'b0, mif.mem_req}, 32'h1);
        step();
        check("pair_stall_n4", {31'b0, stall}, 32'h1);
        step();
        check("pair_stall_n5", {31'b0, stall}, 32'h0);

        // Timeout: mem_ready never arrives.
        c = cyc;
        push_bus(1'b0, 32'h50, 32'h0, 4'h0, 255, 32'h5555_AAAA);
        push_exp(1'b0, 32'h0, c + 2 + TO - 1);
        issue(1'b1, 1'b0, 32'h50, 32'h0, 4'h0, 1'b0, 32'h0);
        wait_idle(300);
        check("timeout_bus_err", {31'b0, bus_err}, 32'h1);
        check("timeout_rdata",   ReadData, 32'h0);

        c = cyc;
        push_bus(1'b0, 32'h300, 32'h0, 4'h0, 0, 32'hE1A0_0000);
        push_exp(1'b1, 32'hE1A0_0000, c + 2);
        issue(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h300);
        wait_idle(300);
        check("bus_err_sticky", {31'b0, bus_err}, 32'h1);

        // Repeat fetch of the same word: buffer hit when the buffer is built in.
        c = cyc;
`ifdef ARM_MEM_BRIDGE_FETCH_BUF_EN
        push_exp(1'b1, 32'hE1A0_0000, c + 1);
`else
        push_bus(1'b0, 32'h300, 32'h0, 4'h0, 0, 32'hE1A0_0000);
        push_exp(1'b1, 32'hE1A0_0000, c + 2);
`endif
        issue(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h302);
        wait_idle(300);

        // A store to that word must force the next fetch back onto the bus.
        c = cyc;
        push_bus(1'b1, 32'h300, 32'h1212_1212, 4'hF, 0, 32'h0);
        push_exp(1'b0, 32'h0, c + 2);
        issue(1'b1, 1'b1, 32'h300, 32'h1212_1212, 4'hF, 1'b0, 32'h0);
        wait_idle(300);
        c = cyc;
        push_bus(1'b0, 32'h300, 32'h0, 4'h0, 0, 32'hE280_0002);
        push_exp(1'b1, 32'hE280_0002, c + 2);
        issue(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h300);
        wait_idle(300);

        // Reset while waiting on the bus.
        push_bus(1'b0, 32'h60, 32'h0, 4'h0, 255, 32'h0);
        issue(1'b1, 1'b0, 32'h60, 32'h0, 4'h0, 1'b0, 32'h0);
        step();
        check("midrst_req_before", {31'b0, mif.mem_req}, 32'h1);
        reset = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_q.delete();
        last_wdata = 32'h0;
        step();
        step();
        reset = 1'b1;
        step();

        c = cyc;
        push_bus(1'b0, 32'h104, 32'h0, 4'h0, 0, 32'hE281_1001);
        push_exp(1'b1, 32'hE281_1001, c + 2);
        issue(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h104);
        wait_idle(300);
        check("post_rst_bus_err", {31'b0, bus_err}, 32'h0);
        step();
        check("exp_q_empty", 32'(exp_q.size()), 32'h0);
        check("bus_q_empty", 32'(bq.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
